// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   S_IDLE / S_RUN / S_DONE : FSM state encodings. 2'd3 is unused and recovers to S_IDLE.
//   WIDTH_MAX               : widest legal operand width.
//   is_busy()               : state decode shared by the top level.
package serial_sub_pkg;

  localparam int unsigned WIDTH_MAX = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // busy covers both the shifting phase and the one-cycle result phase
  function automatic logic is_busy(input state_t s);
    return (s == S_RUN) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
//   start, a, b, bin : request and operands, driven by the controller (master)
//   busy, done       : status, driven by the subtractor (slave)
//   diff, bout       : registered result and borrow-out, driven by the subtractor
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 2
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/full_subtractor.sv
// 1-bit combinational full subtractor: d = a - b - bin (mod 2), bout = borrow out.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out, set when a < b + bin
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;

  assign axb  = a ^ b;
  assign d    = axb ^ bin;
  // borrow when b exceeds a outright, or when a == b and a borrow comes in
  assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor with borrow: diff = a - b - bin over WIDTH cycles, LSB first.
// One full_subtractor is time-shared across all bit positions.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : serial_subtractor_if slave modport
//          start/a/b/bin sampled only in idle; busy/done/diff/bout all registered
// Timing: start accepted at edge k -> done high for the cycle after edge k+WIDTH,
// next request accepted at edge k+WIDTH+2 at the earliest.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_if.slave   bus
);

  // wide enough to hold WIDTH itself so WIDTH=1 still gets a 1-bit counter
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;

  logic             fs_d;
  logic             fs_bout;
  logic [WIDTH-1:0] res_shift;
  logic             last_bit;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // new difference bit enters at the MSB so the LSB-first stream lands in order
  assign res_shift = (res_q >> 1) | (WIDTH'(fs_d) << (WIDTH - 1));
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = fs_bout;
        res_d = res_shift;
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          // result registers update only here; they hold through later runs
          diff_d  = res_shift;
          bout_d  = fs_bout;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  // status is a pure decode of registered state, so no input reaches an output
  assign bus.busy = is_busy(state_q);
  assign bus.done = (state_q == S_DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(2)) if2 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

  logic fa, fb, fbin, fd, fbo;
  full_subtractor u_fs (.a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbo));

  // ---------------- access helpers (width-selected) ----------------
  task automatic set_in(input int w, input logic s, input logic [7:0] a, input logic [7:0] b,
                        input logic bin);
    case (w)
      1: begin if1.start = s; if1.a = a[0:0]; if1.b = b[0:0]; if1.bin = bin; end
      8: begin if8.start = s; if8.a = a;      if8.b = b;      if8.bin = bin; end
      default: begin if2.start = s; if2.a = a[1:0]; if2.b = b[1:0]; if2.bin = bin; end
    endcase
  endtask

  function automatic logic f_done(input int w);
    case (w)
      1: return if1.done;
      8: return if8.done;
      default: return if2.done;
    endcase
  endfunction

  function automatic logic f_busy(input int w);
    case (w)
      1: return if1.busy;
      8: return if8.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [7:0] f_diff(input int w);
    case (w)
      1: return {7'b0, if1.diff};
      8: return if8.diff;
      default: return {6'b0, if2.diff};
    endcase
  endfunction

  function automatic logic f_bout(input int w);
    case (w)
      1: return if1.bout;
      8: return if8.bout;
      default: return if2.bout;
    endcase
  endfunction

  // One request: start for one cycle, operands scrambled after acceptance,
  // lat counts edges from the accepting edge up to and including the one raising done.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output int lat,
                        output logic acc_busy, output logic done_busy, output logic tail_ok);
    @(negedge clk);
    set_in(w, 1'b1, a, b, bin);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, ~a, ~b, ~bin);
    acc_busy = f_busy(w);
    lat = 1;
    while (!f_done(w) && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    d         = f_diff(w);
    bo        = f_bout(w);
    done_busy = f_busy(w);
    @(posedge clk);
    @(negedge clk);
    tail_ok = !f_done(w) && !f_busy(w);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    set_in(1, 1'b0, 8'd0, 8'd0, 1'b0);
    set_in(2, 1'b0, 8'd0, 8'd0, 1'b0);
    set_in(8, 1'b0, 8'd0, 8'd0, 1'b0);
    #2;
    n_cmp++;
    if ({if2.busy, if2.done, if2.diff, if2.bout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_w2: got busy=%b done=%b diff=%0d bout=%b want all 0",
               if2.busy, if2.done, if2.diff, if2.bout);
    end
    n_cmp++;
    if ({if8.busy, if8.done, if8.diff, if8.bout} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_w8: got busy=%b done=%b diff=%0d bout=%b want all 0",
               if8.busy, if8.done, if8.diff, if8.bout);
    end
    n_cmp++;
    if ({if1.busy, if1.done} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_w1: got busy=%b done=%b want 0 0", if1.busy, if1.done);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    // a, b, bin, expected diff, expected bout (WIDTH=2)
    logic [1:0] va   [5] = '{2'd0, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [1:0] vb   [5] = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd0};
    logic       vbin [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] ed   [5] = '{2'd0, 2'd0, 2'd3, 2'd3, 2'd1};
    logic       eb   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [7:0] d;
    logic bo, ab, db, tk;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(2, {6'b0, va[i]}, {6'b0, vb[i]}, vbin[i], d, bo, lat, ab, db, tk);
      n_cmp++;
      if (lat !== 3) begin
        n_fail++; $display("FAIL basic[%0d] latency: got %0d want 3", i, lat);
      end
      n_cmp++;
      if (d !== {6'b0, ed[i]}) begin
        n_fail++; $display("FAIL basic[%0d] diff: got %0d want %0d", i, d, ed[i]);
      end
      n_cmp++;
      if (bo !== eb[i]) begin
        n_fail++; $display("FAIL basic[%0d] bout: got %b want %b", i, bo, eb[i]);
      end
      n_cmp++;
      if ({ab, db, tk} !== 3'b111) begin
        n_fail++;
        $display("FAIL basic[%0d] busy: got accept=%b at_done=%b after_done_clear=%b want 1 1 1",
                 i, ab, db, tk);
      end
    end
  endtask

  task automatic test_start_held;
    logic exp_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_done [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    if2.start = 1'b1; if2.a = 2'd2; if2.b = 2'd1; if2.bin = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 0) begin
        if2.a = 2'd3; if2.b = 2'd0; if2.bin = 1'b1;
      end
      n_cmp++;
      if ({if2.busy, if2.done} !== {exp_busy[i], exp_done[i]}) begin
        n_fail++;
        $display("FAIL held[%0d] busy/done: got %b%b want %b%b", i, if2.busy, if2.done,
                 exp_busy[i], exp_done[i]);
      end
      if (i == 2 || i == 4 || i == 5) begin
        n_cmp++;
        if ({if2.diff, if2.bout} !== {2'd1, 1'b0}) begin
          n_fail++;
          $display("FAIL held[%0d] first result: got diff=%0d bout=%b want 1 0", i, if2.diff,
                   if2.bout);
        end
      end
      if (i == 6) begin
        n_cmp++;
        if ({if2.diff, if2.bout} !== {2'd2, 1'b0}) begin
          n_fail++;
          $display("FAIL held[6] second result: got diff=%0d bout=%b want 2 0", if2.diff,
                   if2.bout);
        end
      end
      if (i == 5) if2.start = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    logic bo, ab, db, tk, seen;
    int lat;
    @(negedge clk);
    if2.start = 1'b1; if2.a = 2'd3; if2.b = 2'd1; if2.bin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if2.start = 1'b0;
    n_cmp++;
    if (if2.busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid accept: got busy=%b want 1", if2.busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({if2.busy, if2.done, if2.diff, if2.bout} !== 5'b0) begin
      n_fail++;
      $display("FAIL rstmid clear: got busy=%b done=%b diff=%0d bout=%b want all 0",
               if2.busy, if2.done, if2.diff, if2.bout);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | if2.done | if2.busy;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL rstmid aborted: got done/busy activity=%b want 0", seen);
    end
    run_op(2, 8'd3, 8'd1, 1'b0, d, bo, lat, ab, db, tk);
    n_cmp++;
    if ({lat, d, bo} !== {32'd3, 8'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid rerun: got lat=%0d diff=%0d bout=%b want 3 2 0", lat, d, bo);
    end
  endtask

  task automatic test_width1;
    logic [7:0] d;
    logic bo, ab, db, tk;
    logic [1:0] m;
    int lat;
    for (int i = 0; i < 8; i++) begin
      logic a, b, bin;
      {a, b, bin} = 3'(i);
      m = {1'b0, a} - {1'b0, b} - {1'b0, bin};
      run_op(1, {7'b0, a}, {7'b0, b}, bin, d, bo, lat, ab, db, tk);
      n_cmp++;
      if ({lat, d, bo, ab, db, tk} !== {32'd2, 7'b0, m[0], m[1], 3'b111}) begin
        n_fail++;
        $display("FAIL w1[%0d] a=%b b=%b bin=%b: got lat=%0d diff=%0d bout=%b busy=%b%b%b want lat=2 diff=%0d bout=%b busy=111",
                 i, a, b, bin, lat, d, bo, ab, db, tk, m[0], m[1]);
      end
    end
  endtask

  task automatic test_width8;
    logic [7:0] va [5] = '{8'd0,   8'd255, 8'd100, 8'd37,  8'd128};
    logic [7:0] vb [5] = '{8'd255, 8'd0,   8'd37,  8'd100, 8'd128};
    logic       vc [5] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1};
    logic [7:0] ed [5] = '{8'd0,   8'd255, 8'd62,  8'd193, 8'd255};
    logic       eb [5] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
    logic [7:0] d, a, b, ex_d;
    logic bo, ab, db, tk, bin, ex_b;
    logic [8:0] m;
    int lat;
    for (int i = 0; i < 21; i++) begin
      if (i < 5) begin
        a = va[i]; b = vb[i]; bin = vc[i]; ex_d = ed[i]; ex_b = eb[i];
      end else begin
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        m = {1'b0, a} - {1'b0, b} - {8'b0, bin};
        ex_d = m[7:0]; ex_b = m[8];
      end
      run_op(8, a, b, bin, d, bo, lat, ab, db, tk);
      n_cmp++;
      if ({lat, d, bo, ab, db, tk} !== {32'd9, ex_d, ex_b, 3'b111}) begin
        n_fail++;
        $display("FAIL w8[%0d] a=%0d b=%0d bin=%b: got lat=%0d diff=%0d bout=%b busy=%b%b%b want lat=9 diff=%0d bout=%b busy=111",
                 i, a, b, bin, lat, d, bo, ab, db, tk, ex_d, ex_b);
      end
    end
  endtask

  task automatic test_full_subtractor;
    logic [1:0] m;
    for (int i = 0; i < 8; i++) begin
      {fa, fb, fbin} = 3'(i);
      m = {1'b0, fa} - {1'b0, fb} - {1'b0, fbin};
      #1;
      n_cmp++;
      if ({fd, fbo} !== {m[0], m[1]}) begin
        n_fail++;
        $display("FAIL fs a=%b b=%b bin=%b: got d=%b bout=%b want d=%b bout=%b",
                 fa, fb, fbin, fd, fbo, m[0], m[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_subtractor();
    test_basic();
    test_start_held();
    test_reset_mid();
    test_width1();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
